// File: rtl/p2arb_pkg.sv
// Shared types for the char-memory port 2 arbiter: return tags, round-robin
// pointer encoding and the width of the optional statistics counters.
package p2arb_pkg;

   typedef enum logic [1:0] {
      TAG_NONE = 2'd0,
      TAG_VID  = 2'd1,
      TAG_BUF  = 2'd2,
      TAG_AUX  = 2'd3
   } tag_t;

   // Round-robin pointer names the side requester that wins a BUF/AUX tie
   localparam logic RR_BUF = 1'b0;
   localparam logic RR_AUX = 1'b1;

   localparam int STAT_W = 16;

endpackage

// File: rtl/p2arb_tag_pipe.sv
// Carries each access's owner tag alongside the memory read latency and
// decodes it into per-requester return valids.
module p2arb_tag_pipe
   import p2arb_pkg::*;
#(
   parameter int RD_LAT = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] tag_in,
   output logic       vid_rvalid,
   output logic       buf_rvalid,
   output logic       aux_rvalid
);

   localparam int STAGES = RD_LAT + 1;

   // Stage 1 lines up with the issued address, stage STAGES with mem_rdata
   logic [STAGES:1][1:0] tag_pipe;

   always_ff @(posedge clk) begin
      if (rst) tag_pipe <= '0;
      else     tag_pipe <= {tag_pipe[STAGES-1:1], tag_in};
   end

   assign vid_rvalid = (tag_pipe[STAGES] == TAG_VID);
   assign buf_rvalid = (tag_pipe[STAGES] == TAG_BUF);
   assign aux_rvalid = (tag_pipe[STAGES] == TAG_AUX);

endmodule

// File: rtl/char_mem_p2_arbiter.sv
// Char-memory port 2 arbiter: VID strict priority, BUF/AUX round-robin with a
// starvation guard. Define P2ARB_STATS_EN to add saturating grant/miss counters.
module char_mem_p2_arbiter
   import p2arb_pkg::*;
#(
   parameter int ADDR_W     = 13,
   parameter int DATA_W     = 8,
   parameter int RD_LAT     = 1,
   parameter int STARVE_LIM = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              vid_req,
   input  logic [ADDR_W-1:0] vid_addr,
   output logic              vid_gnt,
   output logic              vid_rvalid,
   output logic              vid_miss,
   input  logic              buf_req,
   input  logic [ADDR_W-1:0] buf_addr,
   output logic              buf_gnt,
   output logic              buf_rvalid,
   input  logic              aux_req,
   input  logic              aux_we,
   input  logic [ADDR_W-1:0] aux_addr,
   input  logic [DATA_W-1:0] aux_wdata,
   output logic              aux_gnt,
   output logic              aux_rvalid,
   output logic [DATA_W-1:0] rd_data,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
`ifdef P2ARB_STATS_EN
   ,
   output logic [STAT_W-1:0] stat_vid_miss,
   output logic [STAT_W-1:0] stat_buf_gnt,
   output logic [STAT_W-1:0] stat_aux_gnt
`endif
);

   localparam int                CNT_W      = $clog2(STARVE_LIM + 1);
   localparam logic [CNT_W-1:0]  STARVE_MAX = CNT_W'(STARVE_LIM);

   logic [CNT_W-1:0] starve_cnt;
   logic             rr_ptr;
   logic             side_req, starve, pick_buf;
   logic             vid_win, buf_win, aux_win;
   logic [1:0]       tag_in;

   // Grants are suppressed during reset so nothing is issued into a clearing pipe
   always_comb begin
      side_req = buf_req | aux_req;
      starve   = side_req & (starve_cnt >= STARVE_MAX);
      pick_buf = buf_req & (~aux_req | (rr_ptr == RR_BUF));
      vid_win  = ~rst & vid_req & ~starve;
      buf_win  = ~rst & ~vid_win & pick_buf;
      aux_win  = ~rst & ~vid_win & aux_req & ~pick_buf;
      tag_in   = TAG_NONE;
      if (vid_win)                tag_in = TAG_VID;
      else if (buf_win)           tag_in = TAG_BUF;
      else if (aux_win & ~aux_we) tag_in = TAG_AUX;
   end

   assign vid_gnt  = vid_win;
   assign buf_gnt  = buf_win;
   assign aux_gnt  = aux_win;
   assign vid_miss = ~rst & vid_req & starve;

   always_ff @(posedge clk) begin
      if (rst) begin
         mem_addr   <= '0;
         mem_we     <= 1'b0;
         mem_wdata  <= '0;
         rr_ptr     <= RR_BUF;
         starve_cnt <= '0;
      end else begin
         mem_we <= aux_win & aux_we;
         if (vid_win)      mem_addr <= vid_addr;
         else if (buf_win) mem_addr <= buf_addr;
         else if (aux_win) mem_addr <= aux_addr;
         if (aux_win & aux_we) mem_wdata <= aux_wdata;
         if (buf_win)      rr_ptr <= RR_AUX;
         else if (aux_win) rr_ptr <= RR_BUF;
         if (buf_win | aux_win)
            starve_cnt <= '0;
         else if (side_req && starve_cnt != '1)
            starve_cnt <= starve_cnt + 1'b1;
      end
   end

   p2arb_tag_pipe #(.RD_LAT(RD_LAT)) u_tag_pipe (
      .clk        (clk),
      .rst        (rst),
      .tag_in     (tag_in),
      .vid_rvalid (vid_rvalid),
      .buf_rvalid (buf_rvalid),
      .aux_rvalid (aux_rvalid)
   );

   // Return bus idles at zero so it reads clean after reset
   assign rd_data = (vid_rvalid | buf_rvalid | aux_rvalid) ? mem_rdata : '0;

`ifdef P2ARB_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_vid_miss <= '0;
         stat_buf_gnt  <= '0;
         stat_aux_gnt  <= '0;
      end else begin
         if (vid_miss && stat_vid_miss != '1) stat_vid_miss <= stat_vid_miss + 1'b1;
         if (buf_win  && stat_buf_gnt  != '1) stat_buf_gnt  <= stat_buf_gnt + 1'b1;
         if (aux_win  && stat_aux_gnt  != '1) stat_aux_gnt  <= stat_aux_gnt + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_char_mem_p2_arbiter.sv
// Directed bench for char_mem_p2_arbiter with a transaction-level model and
// a behavioural port 2 memory. Honours P2ARB_STATS_EN when defined.
module tb_char_mem_p2_arbiter;

   localparam int ADDR_W = 13;
   localparam int DATA_W = 8;
   localparam int RD_LAT = 1;
   localparam int LIM    = 64;

   logic              clk = 1'b0;
   logic              rst;
   logic              vid_req, buf_req, aux_req, aux_we;
   logic [ADDR_W-1:0] vid_addr, buf_addr, aux_addr;
   logic [DATA_W-1:0] aux_wdata;
   logic              vid_gnt, vid_rvalid, vid_miss;
   logic              buf_gnt, buf_rvalid, aux_gnt, aux_rvalid;
   logic [DATA_W-1:0] rd_data, mem_wdata, mem_rdata;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_we;
`ifdef P2ARB_STATS_EN
   logic [15:0]       stat_vid_miss, stat_buf_gnt, stat_aux_gnt;
`endif

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   char_mem_p2_arbiter #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .STARVE_LIM(LIM)
   ) dut (
      .clk(clk), .rst(rst),
      .vid_req(vid_req), .vid_addr(vid_addr), .vid_gnt(vid_gnt),
      .vid_rvalid(vid_rvalid), .vid_miss(vid_miss),
      .buf_req(buf_req), .buf_addr(buf_addr), .buf_gnt(buf_gnt), .buf_rvalid(buf_rvalid),
      .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr), .aux_wdata(aux_wdata),
      .aux_gnt(aux_gnt), .aux_rvalid(aux_rvalid),
      .rd_data(rd_data), .mem_addr(mem_addr), .mem_we(mem_we),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef P2ARB_STATS_EN
      , .stat_vid_miss(stat_vid_miss), .stat_buf_gnt(stat_buf_gnt), .stat_aux_gnt(stat_aux_gnt)
`endif
   );

   function automatic logic [7:0] init_val(int a);
      return 8'(((a * 7) ^ (a >> 8) ^ 'h3C));
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Behavioural port 2 memory, one cycle read latency
   logic [7:0] mem [0:8191];
   logic       mem_ready = 1'b0;
   always @(posedge clk) begin
      if (!mem_ready) begin
         for (int i = 0; i < 8192; i++) mem[i] <= init_val(i);
         mem_ready <= 1'b1;
      end else begin
         if (mem_we) mem[mem_addr] <= mem_wdata;
         mem_rdata <= mem[mem_addr];
      end
   end

   // Transaction model: who should win, what returns when, and what the port shows
   int          cyc = 0;
   int          waited = 0;
   logic        known = 1'b0, pref_buf = 1'b1, model_ready = 1'b0;
   logic        exp_we = 1'b0;
   logic [12:0] exp_addr = '0;
   logic [7:0]  exp_wdata = '0;
   logic [1:0]  due_own [0:7];
   logic [7:0]  due_dat [0:7];
   logic [7:0]  shadow  [0:8191];

   always @(negedge clk) begin
      logic fv, fb, fa, fm;
      int   slot, due;
      if (!model_ready) begin
         for (int i = 0; i < 8192; i++) shadow[i] = init_val(i);
         model_ready = 1'b1;
      end
      slot = cyc % 8;
      if (known) begin
         check("vid_rvalid", 32'(vid_rvalid), 32'(due_own[slot] == 2'd1));
         check("buf_rvalid", 32'(buf_rvalid), 32'(due_own[slot] == 2'd2));
         check("aux_rvalid", 32'(aux_rvalid), 32'(due_own[slot] == 2'd3));
         if (due_own[slot] != 2'd0) check("rd_data", 32'(rd_data), 32'(due_dat[slot]));
         check("mem_we", 32'(mem_we), 32'(exp_we));
         check("mem_addr", 32'(mem_addr), 32'(exp_addr));
         check("mem_wdata", 32'(mem_wdata), 32'(exp_wdata));
      end
      due_own[slot] = 2'd0;
      fm = !rst && vid_req && (buf_req || aux_req) && waited >= LIM;
      fv = !rst && vid_req && !fm;
      fb = !rst && !fv && buf_req && (!aux_req || pref_buf);
      fa = !rst && !fv && aux_req && !fb;
      check("vid_gnt", 32'(vid_gnt), 32'(fv));
      check("buf_gnt", 32'(buf_gnt), 32'(fb));
      check("aux_gnt", 32'(aux_gnt), 32'(fa));
      check("vid_miss", 32'(vid_miss), 32'(fm));
      if (rst) begin
         waited    = 0;
         pref_buf  = 1'b1;
         exp_we    = 1'b0;
         exp_addr  = '0;
         exp_wdata = '0;
         for (int i = 0; i < 8; i++) due_own[i] = 2'd0;
         known = 1'b1;
      end else begin
         due    = (cyc + 1 + RD_LAT) % 8;
         exp_we = fa && aux_we;
         if (fv) begin
            exp_addr = vid_addr; due_own[due] = 2'd1; due_dat[due] = shadow[vid_addr];
         end else if (fb) begin
            exp_addr = buf_addr; due_own[due] = 2'd2; due_dat[due] = shadow[buf_addr];
         end else if (fa) begin
            exp_addr = aux_addr;
            if (aux_we) begin
               exp_wdata = aux_wdata; shadow[aux_addr] = aux_wdata;
            end else begin
               due_own[due] = 2'd3; due_dat[due] = shadow[aux_addr];
            end
         end
         if (fb || fa)              waited = 0;
         else if (buf_req || aux_req) waited++;
         if (fb)      pref_buf = 1'b0;
         else if (fa) pref_buf = 1'b1;
      end
      cyc++;
   end

   task automatic next();
      @(posedge clk); #1;
   endtask

   task automatic idle(int n);
      vid_req = 1'b0; buf_req = 1'b0; aux_req = 1'b0; aux_we = 1'b0;
      repeat (n) next();
   endtask

   // VID hammers while BUF waits; reports the cycle BUF won and the miss count
   task automatic run_starve(output int gnt_at, output int misses);
      gnt_at = -1; misses = 0;
      buf_req = 1'b1; buf_addr = 13'h800; vid_req = 1'b1;
      for (int k = 0; k < 70; k++) begin
         vid_addr = 13'(13'h400 + k);
         @(negedge clk);
         if (buf_gnt && gnt_at < 0) gnt_at = k;
         if (vid_miss) misses++;
         next();
         if (gnt_at >= 0) buf_req = 1'b0;
      end
      idle(4);
   endtask

   initial begin
      int g, m;
      rst = 1'b1; vid_req = 1'b0; buf_req = 1'b0; aux_req = 1'b0; aux_we = 1'b0;
      vid_addr = '0; buf_addr = '0; aux_addr = '0; aux_wdata = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      @(negedge clk);
      check("rst_gnt", 32'({vid_gnt, buf_gnt, aux_gnt, vid_miss}), 32'(0));
      check("rst_rvalid", 32'({vid_rvalid, buf_rvalid, aux_rvalid}), 32'(0));
      check("rst_port", 32'({mem_we, mem_addr, mem_wdata, rd_data}), 32'(0));
      next();

      // VID alone over the first 1K addresses
      vid_req = 1'b1;
      for (int k = 0; k < 1026; k++) begin
         if (k < 1024) vid_addr = 13'(k);
         else          vid_req = 1'b0;
         @(negedge clk);
         if (k == 18) begin
            check("t1_lit_rvalid", 32'(vid_rvalid), 32'(1));
            check("t1_lit_data", 32'(rd_data), 32'(8'h4C));
         end
         next();
      end
      idle(3);

      // BUF and AUX reads held together
      buf_req = 1'b1; aux_req = 1'b1; aux_we = 1'b0;
      for (int k = 0; k < 8; k++) begin
         buf_addr = 13'(13'h800 + k);
         aux_addr = 13'(13'h100 + k);
         @(negedge clk);
         if (k < 4) begin
            check("t2_lit_buf", 32'(buf_gnt), 32'(k % 2 == 0));
            check("t2_lit_aux", 32'(aux_gnt), 32'(k % 2 == 1));
         end
         next();
      end
      idle(4);

      // AUX write followed directly by a read of the same address
      begin
         logic seen;
         logic [7:0] got;
         seen = 1'b0; got = '0;
         aux_req = 1'b1; aux_we = 1'b1; aux_addr = 13'h8A0; aux_wdata = 8'h5A;
         next();
         aux_we = 1'b0; aux_wdata = 8'h00;
         next();
         aux_req = 1'b0;
         for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            if (aux_rvalid && !seen) begin seen = 1'b1; got = rd_data; end
            next();
         end
         check("t4_lit_seen", 32'(seen), 32'(1));
         check("t4_lit_data", 32'(got), 32'(8'h5A));
      end

      // Reset lands on the cycle after a VID grant
      vid_req = 1'b1; vid_addr = 13'h050;
      next();
      vid_req = 1'b0; rst = 1'b1;
      next();
      rst = 1'b0;
      @(negedge clk);
      check("t5_lit_rvalid", 32'({vid_rvalid, buf_rvalid, aux_rvalid}), 32'(0));
      check("t5_lit_gnt", 32'({vid_gnt, buf_gnt, aux_gnt, vid_miss}), 32'(0));
      check("t5_lit_port", 32'({mem_we, mem_addr, mem_wdata, rd_data}), 32'(0));
      next();
      idle(2);

      // Starvation guard, three times from a clean reset
      for (int r = 0; r < 3; r++) begin
         run_starve(g, m);
         check("t3_lit_gnt_cycle", 32'(g), 32'(64));
         check("t3_lit_miss_count", 32'(m), 32'(1));
      end
`ifdef P2ARB_STATS_EN
      check("t6_stat_vid_miss", 32'(stat_vid_miss), 32'(3));
      check("t6_stat_buf_gnt", 32'(stat_buf_gnt), 32'(3));
      check("t6_stat_aux_gnt", 32'(stat_aux_gnt), 32'(0));
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: run did not finish, vectors=%0d miscompares=%0d", vectors, miscompares);
      $fatal(1, "watchdog");
   end

endmodule
